apb_uart_cmd_master: RTL and testbench
======================================

// Module: apb_uart_cmd_master
// PURPOSE
//  Upstream APB requester for APB_UART. Queues simple read/write commands from
//  the host-side request port and issues each one as a compliant two-phase APB
//  transfer (SETUP, ACCESS, wait for PREADY). Returns one response per command.
//  Shares PCLK/PRESETn with APB_UART and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA.
// PARAMETERS
//  ADDR_W       12    APB address width (UART map: 0x400 data, 0x404 state, 0x408 ctrl, 0x410 baud)
//  WDATA_W      8     PWDATA width
//  RDATA_W      32    PRDATA / rsp_rdata width
//  CMD_DEPTH    4     command queue entries; power of 2, >= 2
//  TIMEOUT_CYC  1024  ACCESS-phase wait limit in PCLK cycles (APB_TIMEOUT_EN only)
// PORTS
//  PCLK        in   1        sole clock
//  PRESETn     in   1        reset: synchronous, active-low
//  cmd_valid   in   1        host command present
//  cmd_ready   out  1        queue not full; command accepted when valid & ready
//  cmd_write   in   1        1 = write, 0 = read
//  cmd_addr    in   ADDR_W   target address
//  cmd_wdata   in   WDATA_W  write data (ignored on reads)
//  rsp_valid   out  1        one-cycle pulse per completed command
//  rsp_rdata   out  RDATA_W  captured PRDATA for reads, 0 for writes
//  rsp_error   out  1        1 = transfer aborted by timeout (valid with rsp_valid)
//  busy        out  1        queue non-empty or transfer in flight
//  PSEL        out  1        APB select
//  PENABLE     out  1        APB enable
//  PWRITE      out  1        APB direction
//  PADDR       out  ADDR_W   APB address
//  PWDATA      out  WDATA_W  APB write data
//  PREADY      in   1        APB completer ready
//  PRDATA      in   RDATA_W  APB read data
// BEHAVIOUR
//  - Reset (PRESETn=0 at PCLK rise): queue flushed, FSM IDLE, all outputs 0 except cmd_ready=1.
//  - Queue: circular buffer, wrap-around pointers plus count. cmd_ready = (count != CMD_DEPTH).
//    Push and pop in the same cycle are legal and leave count unchanged. No push while full.
//  - FSM IDLE: PSEL=0, PENABLE=0. Queue non-empty -> SETUP on next edge.
//  - SETUP: PSEL=1, PENABLE=0; PADDR/PWRITE/PWDATA driven from queue head, held stable
//    through ACCESS. Always -> ACCESS after exactly one cycle.
//  - ACCESS: PSEL=1, PENABLE=1. PREADY=0 -> stay. PREADY=1 -> pop head, register
//    rsp_valid=1 next cycle with rsp_rdata = PWRITE ? 0 : PRDATA (sampled at that edge),
//    rsp_error=0. Next state SETUP if queue still non-empty, else IDLE.
//  - Latency: command pushed at edge N into empty queue -> SETUP during N+1, ACCESS during
//    N+2, rsp_valid during N+3 when PREADY=1 in ACCESS. Back-to-back: 2 cycles/transfer.
//  - Outputs in IDLE: PADDR/PWDATA/PWRITE hold last values; PSEL=PENABLE=0.
//  - busy = (count != 0) | (state != IDLE).
//  - Reset mid-transfer: transfer abandoned, no response issued, PSEL drops the following cycle.
// CONFIGURATION
//  APB_TIMEOUT_EN defined: cycle counter cleared on entry to ACCESS, counts while PREADY=0.
//    Counter reaching TIMEOUT_CYC-1 with PREADY still 0 -> pop head, rsp_valid=1,
//    rsp_error=1, rsp_rdata=0, next state SETUP/IDLE as for normal completion.
//    PREADY=1 on the limit cycle -> normal completion wins.
//  APB_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely; rsp_error tied 0.
// TESTING
//  1 Reset then write 0x410 data 0x00, PREADY=1 -> PSEL rises N+1, PENABLE N+2, rsp_valid N+3, rdata 0.
//  2 Push 4 writes to 0x400 (0xD8,0x48,0x45,0x4C), PREADY=1 -> cmd_ready=0 after 4th, 4 transfers 2 cycles apart, PWDATA order kept.
//  3 Read 0x404, PREADY low 5 cycles then high with PRDATA=0x0000_00A5 -> PENABLE held 6 cycles, rsp_rdata=0xA5.
//  4 Push while popping on full queue (count=4, PREADY=1) -> count stays 4 when ready; no loss, no duplicate.
//  5 PRESETn=0 during ACCESS with 2 queued -> next cycle PSEL=0, busy=0, no rsp_valid.
//  6 APB_TIMEOUT_EN, TIMEOUT_CYC=16, PREADY stuck 0 -> rsp_valid with rsp_error=1 after 16 ACCESS cycles; next command proceeds.

Source files
------------

// File: rtl/apb_uart_cmd_master.sv
// apb_uart_cmd_master: queues host read/write commands and issues each as a two-phase APB transfer.
// Optional ACCESS-phase timeout is compiled in when APB_TIMEOUT_EN is defined.
module apb_uart_cmd_master #(
    parameter int ADDR_W      = 12,
    parameter int WDATA_W     = 8,
    parameter int RDATA_W     = 32,
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [WDATA_W-1:0] cmd_wdata,
    output logic               rsp_valid,
    output logic [RDATA_W-1:0] rsp_rdata,
    output logic               rsp_error,
    output logic               busy,
    output logic               PSEL,
    output logic               PENABLE,
    output logic               PWRITE,
    output logic [ADDR_W-1:0]  PADDR,
    output logic [WDATA_W-1:0] PWDATA,
    input  logic               PREADY,
    input  logic [RDATA_W-1:0] PRDATA
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = 1 + ADDR_W + WDATA_W;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CMD_DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO_CNT = CNT_W'(0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t               state_r, state_nxt_s;
    logic [ENT_W-1:0]     mem_r [CMD_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_r, rd_ptr_r, head_idx_s;
    logic [CNT_W-1:0]     count_r, count_nxt_s;
    logic [ENT_W-1:0]     head_s;
    logic                 push_s, pop_s, complete_s, timeout_s, timeout_hit_s;
    logic                 cmd_ready_r, rsp_valid_r, rsp_error_r, busy_r;
    logic                 psel_r, penable_r, pwrite_r;
    logic [RDATA_W-1:0]   rsp_rdata_r;
    logic [ADDR_W-1:0]    paddr_r;
    logic [WDATA_W-1:0]   pwdata_r;

    assign push_s    = cmd_valid & cmd_ready_r;
    assign pop_s     = complete_s | timeout_s;
    assign cmd_ready = cmd_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;
    assign busy      = busy_r;
    assign PSEL      = psel_r;
    assign PENABLE   = penable_r;
    assign PWRITE    = pwrite_r;
    assign PADDR     = paddr_r;
    assign PWDATA    = pwdata_r;

    // ACCESS-phase termination: PREADY wins over a coincident timeout
    always_comb begin
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        if (state_r == ST_ACCESS) begin
            complete_s = PREADY;
            timeout_s  = ~PREADY & timeout_hit_s;
        end else begin
            complete_s = 1'b0;
            timeout_s  = 1'b0;
        end
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + ONE_CNT;
            2'b01:   count_nxt_s = count_r - ONE_CNT;
            default: count_nxt_s = count_r;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (count_r != ZERO_CNT) state_nxt_s = ST_SETUP;
                else                     state_nxt_s = ST_IDLE;
            end
            ST_SETUP:  state_nxt_s = ST_ACCESS;
            ST_ACCESS: begin
                if (pop_s) begin
                    if (count_nxt_s != ZERO_CNT) state_nxt_s = ST_SETUP;
                    else                         state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_ACCESS;
                end
            end
            default:   state_nxt_s = ST_IDLE;
        endcase
    end

    // Head seen by the next SETUP; a lone entry popped alongside a push means the
    // new head is the command being written this very edge
    always_comb begin
        head_idx_s = pop_s ? (rd_ptr_r + PTR_W'(1)) : rd_ptr_r;
        if (pop_s && (count_r == ONE_CNT)) head_s = {cmd_write, cmd_addr, cmd_wdata};
        else                               head_s = mem_r[head_idx_s];
    end

    // Command queue storage, pointers and occupancy
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            wr_ptr_r    <= {PTR_W{1'b0}};
            rd_ptr_r    <= {PTR_W{1'b0}};
            count_r     <= ZERO_CNT;
            cmd_ready_r <= 1'b1;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= {cmd_write, cmd_addr, cmd_wdata};
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            count_r     <= count_nxt_s;
            cmd_ready_r <= (count_nxt_s != FULL_CNT);
        end
    end

    // State register
    always_ff @(posedge PCLK) begin
        if (!PRESETn) state_r <= ST_IDLE;
        else          state_r <= state_nxt_s;
    end

    // APB request outputs; address/data/direction hold their last values in IDLE
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            psel_r    <= 1'b0;
            penable_r <= 1'b0;
            pwrite_r  <= 1'b0;
            paddr_r   <= {ADDR_W{1'b0}};
            pwdata_r  <= {WDATA_W{1'b0}};
            busy_r    <= 1'b0;
        end else begin
            psel_r    <= (state_nxt_s != ST_IDLE);
            penable_r <= (state_nxt_s == ST_ACCESS);
            busy_r    <= (count_nxt_s != ZERO_CNT) | (state_nxt_s != ST_IDLE);
            if (state_nxt_s == ST_SETUP) {pwrite_r, paddr_r, pwdata_r} <= head_s;
        end
    end

    // One-cycle response per retired command
    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            rsp_valid_r <= 1'b0;
            rsp_error_r <= 1'b0;
            rsp_rdata_r <= {RDATA_W{1'b0}};
        end else begin
            rsp_valid_r <= pop_s;
            rsp_error_r <= timeout_s;
            rsp_rdata_r <= (complete_s & ~pwrite_r) ? PRDATA : {RDATA_W{1'b0}};
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    logic [TO_W-1:0] to_cnt_r;

    assign timeout_hit_s = (to_cnt_r == TO_LAST);

    // Wait counter: zero on ACCESS entry, advances while the completer stalls
    always_ff @(posedge PCLK) begin
        if (!PRESETn)                   to_cnt_r <= {TO_W{1'b0}};
        else if (state_r != ST_ACCESS)  to_cnt_r <= {TO_W{1'b0}};
        else if (!PREADY)               to_cnt_r <= to_cnt_r + TO_W'(1);
        else                            to_cnt_r <= to_cnt_r;
    end
`else
    assign timeout_hit_s = 1'b0;
`endif

endmodule

// File: tb/tb_apb_uart_cmd_master.sv
// Directed bench for apb_uart_cmd_master: latency, queue ordering, wait states, reset and timeout.
module tb_apb_uart_cmd_master;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [11:0] cmd_addr = 12'h000;
    logic [7:0]  cmd_wdata = 8'h00;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        busy;
    logic        PSEL, PENABLE, PWRITE;
    logic [11:0] PADDR;
    logic [7:0]  PWDATA;
    logic        PREADY = 1'b1;
    logic [31:0] PRDATA = 32'h0;

    int total = 0;
    int bad   = 0;
    logic [7:0] rec_data [$];
    int         rec_cyc  [$];
    int  nrsp, acc, pen_cnt, got;
    logic pushing, accepted, cap_err;
    logic [31:0] cap_rdata;

    apb_uart_cmd_master #(.TIMEOUT_CYC(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .PRDATA(PRDATA)
    );

    always #5 PCLK = ~PCLK;

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic w, input logic [11:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        PRESETn = 1'b0;
        tick();
        tick();
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        PRESETn = 1'b1;
        tick();

        // 1: single write, latency N+1/N+2/N+3, write returns rdata 0
        PREADY = 1'b1;
        PRDATA = 32'h1234_5678;
        push(1'b1, 12'h410, 8'h00);
        check("t1_n_psel", PSEL, 0);
        check("t1_n_busy", busy, 1);
        tick();
        check("t1_n1_psel", PSEL, 1);
        check("t1_n1_penable", PENABLE, 0);
        check("t1_n1_paddr", PADDR, 32'h410);
        check("t1_n1_pwrite", PWRITE, 1);
        tick();
        check("t1_n2_penable", PENABLE, 1);
        check("t1_n2_rsp_valid", rsp_valid, 0);
        tick();
        check("t1_n3_rsp_valid", rsp_valid, 1);
        check("t1_n3_rsp_rdata", rsp_rdata, 0);
        check("t1_n3_rsp_error", rsp_error, 0);
        check("t1_n3_psel", PSEL, 0);
        check("t1_n3_busy", busy, 0);
        tick();
        check("t1_n4_rsp_pulse", rsp_valid, 0);

        // 2: fill queue with four writes, then drain back-to-back
        PREADY = 1'b0;
        push(1'b1, 12'h400, 8'hD8);
        push(1'b1, 12'h400, 8'h48);
        push(1'b1, 12'h400, 8'h45);
        push(1'b1, 12'h400, 8'h4C);
        check("t2_full_ready", cmd_ready, 0);
        PREADY = 1'b1;
        rec_data.delete();
        rec_cyc.delete();
        nrsp = 0;
        for (int c = 0; c < 20; c++) begin
            if (PSEL && PENABLE) begin
                rec_data.push_back(PWDATA);
                rec_cyc.push_back(c);
            end
            if (rsp_valid) nrsp++;
            tick();
        end
        check("t2_nxfer", rec_data.size(), 4);
        check("t2_nrsp", nrsp, 4);
        check("t2_busy_end", busy, 0);
        if (rec_data.size() == 4) begin
            check("t2_d0", rec_data[0], 32'hD8);
            check("t2_d1", rec_data[1], 32'h48);
            check("t2_d2", rec_data[2], 32'h45);
            check("t2_d3", rec_data[3], 32'h4C);
            for (int i = 1; i < 4; i++) check("t2_gap", rec_cyc[i] - rec_cyc[i-1], 2);
        end

        // 3: read with five wait states
        PREADY = 1'b0;
        PRDATA = 32'hDEAD_BEEF;
        push(1'b0, 12'h404, 8'h00);
        tick();
        check("t3_setup_pwrite", PWRITE, 0);
        check("t3_setup_paddr", PADDR, 32'h404);
        tick();
        pen_cnt = 0;
        got = 0;
        cap_rdata = 32'h0;
        cap_err = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (PENABLE) pen_cnt++;
            if (i == 5) begin
                PREADY = 1'b1;
                PRDATA = 32'h0000_00A5;
            end
            tick();
            if (rsp_valid) begin
                got = 1;
                cap_rdata = rsp_rdata;
                cap_err = rsp_error;
                break;
            end
        end
        check("t3_got_rsp", got, 1);
        check("t3_penable_cycles", pen_cnt, 6);
        check("t3_rdata", cap_rdata, 32'hA5);
        check("t3_err", cap_err, 0);
        PRDATA = 32'h0;
        tick();

        // 4: push while popping from a full queue
        PREADY = 1'b0;
        for (int i = 0; i < 4; i++) push(1'b1, 12'h408, 8'(i + 1));
        check("t4_full", cmd_ready, 0);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 12'h408;
        cmd_wdata = 8'h05;
        PREADY = 1'b1;
        accepted = 1'b0;
        rec_data.delete();
        for (int c = 0; c < 30; c++) begin
            if (PSEL && PENABLE) rec_data.push_back(PWDATA);
            pushing = cmd_valid && cmd_ready;
            tick();
            if (pushing) begin
                cmd_valid = 1'b0;
                accepted = 1'b1;
                check("t4_refull_ready", cmd_ready, 0);
            end
        end
        check("t4_accepted", accepted, 1);
        check("t4_nxfer", rec_data.size(), 5);
        if (rec_data.size() == 5) begin
            for (int i = 0; i < 5; i++) check("t4_order", rec_data[i], i + 1);
        end

        // 5: reset during ACCESS with commands queued
        PREADY = 1'b0;
        push(1'b1, 12'h408, 8'hAA);
        push(1'b1, 12'h408, 8'hBB);
        push(1'b1, 12'h408, 8'hCC);
        check("t5_in_access", PENABLE, 1);
        PRESETn = 1'b0;
        tick();
        check("t5_psel", PSEL, 0);
        check("t5_penable", PENABLE, 0);
        check("t5_busy", busy, 0);
        check("t5_rsp_valid", rsp_valid, 0);
        check("t5_cmd_ready", cmd_ready, 1);
        PRESETn = 1'b1;
        PREADY = 1'b1;
        nrsp = 0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (rsp_valid) nrsp++;
            if (PSEL) acc++;
        end
        check("t5_no_rsp_after", nrsp, 0);
        check("t5_no_psel_after", acc, 0);

`ifdef APB_TIMEOUT_EN
        // 6: stuck completer times out after 16 ACCESS cycles
        PREADY = 1'b0;
        push(1'b1, 12'h400, 8'h11);
        tick();
        tick();
        acc = 0;
        got = 0;
        cap_err = 1'b0;
        cap_rdata = 32'hFFFF_FFFF;
        for (int c = 0; c < 40; c++) begin
            if (PENABLE) acc++;
            tick();
            if (rsp_valid) begin
                got = 1;
                cap_err = rsp_error;
                cap_rdata = rsp_rdata;
                break;
            end
        end
        check("t6_got_rsp", got, 1);
        check("t6_access_cycles", acc, 16);
        check("t6_err", cap_err, 1);
        check("t6_rdata", cap_rdata, 0);
        PREADY = 1'b1;
        PRDATA = 32'h0000_005A;
        push(1'b0, 12'h404, 8'h00);
        tick();
        tick();
        tick();
        check("t6_next_valid", rsp_valid, 1);
        check("t6_next_err", rsp_error, 0);
        check("t6_next_rdata", rsp_rdata, 32'h5A);
`else
        // 6: without the timeout, ACCESS waits indefinitely
        PREADY = 1'b0;
        push(1'b1, 12'h400, 8'h11);
        nrsp = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (rsp_valid) nrsp++;
        end
        check("t6_no_rsp", nrsp, 0);
        check("t6_still_access", PENABLE, 1);
        PREADY = 1'b1;
        tick();
        check("t6_late_valid", rsp_valid, 1);
        check("t6_late_err", rsp_error, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
